// File: rtl/ieee488_acceptor.sv
// IEEE-488 listener-side acceptor: synchronizes the bus, runs the NRFD/NDAC
// acceptor handshake, decodes addressing commands and buffers data bytes.
`timescale 1ns/1ps
module ieee488_acceptor #(
  parameter logic [4:0] DEVADDR    = 5'd8,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       dav_n,
  input  logic       atn_n,
  input  logic       ifc_n,
  input  logic       eoi_n,
  input  logic [7:0] dio_n,
  output logic       nrfd_n,
  output logic       ndac_n,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       listen,
  output logic [4:0] sec_addr
);

  localparam int            AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   L_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PINC = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RDY, S_ACC, S_WNV} state_t;

  logic [11:0]   r_sync1;
  logic [11:0]   r_sync2;
  state_t        r_state;
  logic          r_nrfd_n;
  logic          r_ndac_n;
  logic          r_listen;
  logic [4:0]    r_sec_addr;
  logic [7:0]    r_lat_byte;
  logic          r_lat_eoi;
  logic          r_lat_cmd;
  logic [7:0]    r_mem_data [FIFO_DEPTH];
  logic          r_mem_eoi  [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic       w_dav_n, w_atn_n, w_ifc_n, w_eoi_n;
  logic [7:0] w_dio_n;
  logic       w_part, w_full, w_block, w_accept, w_pop, w_push, w_wr;
  logic [6:0] w_cmd;
  logic       w_c_lad, w_c_unl, w_c_tad, w_c_sad;

  // Bus lines idle high, so the synchronizer powers up to the released value.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {dio_n, eoi_n, ifc_n, atn_n, dav_n};
      r_sync2 <= r_sync1;
    end
  end

  assign w_dav_n = r_sync2[0];
  assign w_atn_n = r_sync2[1];
  assign w_ifc_n = r_sync2[2];
  assign w_eoi_n = r_sync2[3];
  assign w_dio_n = r_sync2[11:4];

  assign w_part   = ~w_atn_n | r_listen;
  assign w_full   = (r_count == L_FULL);
  assign w_block  = w_atn_n & w_full;
  assign w_accept = (r_state == S_RDY) & w_ifc_n & w_part & ~w_dav_n & ~w_block;
  assign rx_valid = (r_count != '0);
  assign w_pop    = rx_valid & rx_ready;
  assign w_push   = (r_state == S_ACC) & w_ifc_n & ~r_lat_cmd & r_listen;
  assign w_wr     = w_push & (~w_full | w_pop);

  assign w_cmd   = r_lat_byte[6:0];
  assign w_c_lad = (w_cmd == {2'b01, DEVADDR});
  assign w_c_unl = (w_cmd == 7'h3F);
  assign w_c_tad = (w_cmd[6:5] == 2'b10) && (w_cmd[4:0] == DEVADDR) && (w_cmd != 7'h5F);
  assign w_c_sad = (w_cmd[6:5] == 2'b11);

  always_ff @(posedge clk_sys) begin
    if (w_accept) begin
      r_lat_byte <= ~w_dio_n;
      r_lat_eoi  <= ~w_eoi_n;
      r_lat_cmd  <= ~w_atn_n;
    end
  end

  // Acceptor FSM; handshake outputs are registered alongside the next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_nrfd_n   <= 1'b1;
      r_ndac_n   <= 1'b1;
      r_listen   <= 1'b0;
      r_sec_addr <= '0;
    end else if (!w_ifc_n) begin
      r_state    <= S_IDLE;
      r_nrfd_n   <= 1'b1;
      r_ndac_n   <= 1'b1;
      r_listen   <= 1'b0;
      r_sec_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_part) begin
            r_nrfd_n <= 1'b1;
            r_ndac_n <= 1'b1;
          end else if (w_dav_n) begin
            r_state  <= S_RDY;
            r_nrfd_n <= ~w_block;
            r_ndac_n <= 1'b0;
          end else begin
            r_nrfd_n <= 1'b0;
            r_ndac_n <= 1'b0;
          end
        end
        S_RDY: begin
          if (!w_part) begin
            r_state  <= S_IDLE;
            r_nrfd_n <= 1'b1;
            r_ndac_n <= 1'b1;
          end else if (w_accept) begin
            r_state  <= S_ACC;
            r_nrfd_n <= 1'b0;
            r_ndac_n <= 1'b0;
          end else begin
            r_nrfd_n <= ~w_block;
            r_ndac_n <= 1'b0;
          end
        end
        S_ACC: begin
          r_state  <= S_WNV;
          r_nrfd_n <= 1'b0;
          r_ndac_n <= 1'b1;
          if (r_lat_cmd) begin
            if (w_c_unl || w_c_tad) r_listen <= 1'b0;
            else if (w_c_lad)       r_listen <= 1'b1;
            else if (w_c_sad && r_listen) r_sec_addr <= w_cmd[4:0];
          end
        end
        S_WNV: begin
          if (w_dav_n) begin
            if (w_part) begin
              r_state  <= S_RDY;
              r_nrfd_n <= ~w_block;
              r_ndac_n <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_nrfd_n <= 1'b1;
              r_ndac_n <= 1'b1;
            end
          end else begin
            r_nrfd_n <= 1'b0;
            r_ndac_n <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_nrfd_n <= 1'b1;
          r_ndac_n <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + L_PINC;
      if (w_pop) r_rptr <= r_rptr + L_PINC;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr) begin
      r_mem_data[r_wptr] <= r_lat_byte;
      r_mem_eoi[r_wptr]  <= r_lat_eoi;
    end
  end

  assign nrfd_n   = r_nrfd_n;
  assign ndac_n   = r_ndac_n;
  assign listen   = r_listen;
  assign sec_addr = r_sec_addr;
  assign rx_data  = rx_valid ? r_mem_data[r_rptr] : 8'h00;
  assign rx_eoi   = rx_valid & r_mem_eoi[r_rptr];

endmodule

// File: tb/tb_ieee488_acceptor.sv
// Talker-side bench for ieee488_acceptor: directed bus scenarios plus random
// command/data traffic checked against a transaction-level listener model.
`timescale 1ns/1ps
module tb_ieee488_acceptor;

  localparam logic [4:0] DEV = 5'd8;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       dav_n = 1'b1, atn_n = 1'b1, ifc_n = 1'b1, eoi_n = 1'b1;
  logic [7:0] dio_n = 8'hFF;
  logic       nrfd_n, ndac_n, rx_eoi, rx_valid, listen;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic [4:0] sec_addr;

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_pop  = 1'b0;
  bit man_ready = 1'b0;

  bit         m_listen = 1'b0;
  logic [4:0] m_sec    = 5'd0;
  logic [8:0] m_q[$];

  ieee488_acceptor #(.DEVADDR(DEV), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dav_n(dav_n), .atn_n(atn_n),
    .ifc_n(ifc_n), .eoi_n(eoi_n), .dio_n(dio_n), .nrfd_n(nrfd_n),
    .ndac_n(ndac_n), .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .listen(listen), .sec_addr(sec_addr)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Listener behaviour described per byte, not per clock.
  task automatic model_byte(input bit cmd, input logic [7:0] b, input bit eoi);
    logic [6:0] c;
    c = b[6:0];
    if (cmd) begin
      if (c == 7'h3F) m_listen = 1'b0;
      else if (c >= 7'h40 && c <= 7'h5E && (c - 7'h40) == {2'b00, DEV}) m_listen = 1'b0;
      else if (c == 7'h20 + {2'b00, DEV}) m_listen = 1'b1;
      else if (c >= 7'h60 && m_listen) m_sec = 5'(c - 7'h60);
    end else if (m_listen) begin
      m_q.push_back({eoi, b});
    end
  endtask

  task automatic set_atn(input logic v);
    if (atn_n !== v) begin
      atn_n = v;
      repeat (4) @(negedge clk_sys);
    end
  endtask

  task automatic send_byte(input bit cmd, input logic [7:0] b, input bit eoi);
    bit part, got, seen_low;
    part = cmd || m_listen;
    seen_low = 1'b0;
    dio_n = ~b;
    eoi_n = ~eoi;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      if (nrfd_n) begin got = 1'b1; break; end
    end
    check_val("hs_nrfd_high", 32'(got), 32'(1));
    dav_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys);
      seen_low = seen_low | ~nrfd_n | ~ndac_n;
      if (ndac_n) begin
        got = 1'b1;
        model_byte(cmd, b, eoi);
        break;
      end
    end
    check_val("hs_ndac_high", 32'(got), 32'(1));
    repeat (3) begin @(negedge clk_sys); seen_low = seen_low | ~nrfd_n | ~ndac_n; end
    dav_n = 1'b1;
    repeat (4) begin @(negedge clk_sys); seen_low = seen_low | ~nrfd_n | ~ndac_n; end
    if (!part) check_val("idle_lines", 32'(seen_low), 32'(0));
    check_val("listen", 32'(listen), 32'(m_listen));
    check_val("sec_addr", 32'(sec_addr), 32'(m_sec));
    eoi_n = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk_sys);
    man_ready = 1'b1;
    #2;
    man_ready = 1'b0;
  endtask

  // Consumer: drives rx_ready and checks every pop against the model queue.
  initial forever begin
    @(negedge clk_sys);
    #1;
    rx_ready = auto_pop ? 1'($urandom_range(0, 1)) : man_ready;
    if (reset_n && rx_valid && rx_ready) begin
      if (m_q.size() == 0) check_val("pop_unexpected", 32'(1), 32'(0));
      else begin
        check_val("pop_byte", 32'({rx_eoi, rx_data}), 32'(m_q[0]));
        void'(m_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp5 [4];
    int r;
    logic [7:0] b;
    exp5 = '{9'h051, 9'h052, 9'h053, 9'h199};

    repeat (3) @(negedge clk_sys);
    check_val("rst_nrfd", 32'(nrfd_n), 32'(1));
    check_val("rst_ndac", 32'(ndac_n), 32'(1));
    check_val("rst_listen", 32'(listen), 32'(0));
    check_val("rst_rx_valid", 32'(rx_valid), 32'(0));
    check_val("rst_rx_data", 32'({rx_eoi, rx_data}), 32'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Addressed as listener by MLA.
    set_atn(1'b0);
    send_byte(1'b1, 8'h28, 1'b0);
    check_val("mla_listen", 32'(listen), 32'(1));
    check_val("mla_nrfd_back", 32'(nrfd_n), 32'(1));

    // Secondary address then two data bytes, EOI on the last.
    send_byte(1'b1, 8'h62, 1'b0);
    check_val("sad_value", 32'(sec_addr), 32'(2));
    set_atn(1'b1);
    send_byte(1'b0, 8'h41, 1'b0);
    send_byte(1'b0, 8'h42, 1'b1);
    check_val("head_41", 32'({rx_valid, rx_eoi, rx_data}), 32'(10'h241));
    pop_one();
    @(negedge clk_sys);
    check_val("head_42", 32'({rx_valid, rx_eoi, rx_data}), 32'(10'h342));
    pop_one();
    @(negedge clk_sys);
    check_val("empty_after_pops", 32'(rx_valid), 32'(0));

    // Full buffer holds off the fifth byte until one pop.
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(8'h50 + i), 1'b0);
    dio_n = ~8'h99;
    repeat (12) @(negedge clk_sys);
    check_val("full_nrfd_low", 32'(nrfd_n), 32'(0));
    check_val("full_head", 32'(rx_data), 32'(8'h50));
    pop_one();
    send_byte(1'b0, 8'h99, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      check_val("drain5_head", 32'({rx_eoi, rx_data}), 32'(exp5[i]));
      pop_one();
    end
    @(negedge clk_sys);
    check_val("drain5_empty", 32'(rx_valid), 32'(0));

    // UNL, then a data byte must be ignored.
    set_atn(1'b0);
    send_byte(1'b1, 8'h3F, 1'b0);
    set_atn(1'b1);
    check_val("unl_listen", 32'(listen), 32'(0));
    send_byte(1'b0, 8'h77, 1'b1);
    check_val("unl_fifo", 32'(rx_valid), 32'(0));

    // Random traffic with a randomly stalling consumer.
    auto_pop = 1'b1;
    set_atn(1'b0);
    send_byte(1'b1, 8'h28, 1'b0);
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        set_atn(1'b1);
        send_byte(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        case (r)
          5:       b = 8'h28;
          6:       b = 8'h60 | 8'($urandom_range(0, 31));
          7:       b = ($urandom_range(0, 2) == 0) ? 8'h3F : (8'h20 | 8'($urandom_range(0, 31)));
          8:       b = ($urandom_range(0, 2) == 0) ? 8'h48 : (8'h40 | 8'($urandom_range(0, 31)));
          default: b = 8'($urandom);
        endcase
        b = b | (8'($urandom_range(0, 1)) << 7);
        set_atn(1'b0);
        send_byte(1'b1, b, 1'b0);
      end
    end
    for (int i = 0; i < 300 && m_q.size() > 0; i++) @(negedge clk_sys);
    auto_pop = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_val("rand_drained", 32'({rx_valid, 1'(m_q.size() != 0)}), 32'(0));

    // IFC while the acceptor is in ACC: listener cleared, buffer kept.
    set_atn(1'b0);
    send_byte(1'b1, 8'h28, 1'b0);
    send_byte(1'b1, 8'h61, 1'b0);
    set_atn(1'b1);
    send_byte(1'b0, 8'h33, 1'b0);
    dio_n = ~8'hC4;
    @(negedge clk_sys);
    check_val("pre_ifc_nrfd", 32'(nrfd_n), 32'(1));
    dav_n = 1'b0;
    @(negedge clk_sys);
    ifc_n = 1'b0;
    @(negedge clk_sys);
    ifc_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    m_listen = 1'b0;
    m_sec = 5'd0;
    check_val("ifc_lines", 32'({nrfd_n, ndac_n}), 32'(2'b11));
    check_val("ifc_listen", 32'(listen), 32'(0));
    check_val("ifc_sec", 32'(sec_addr), 32'(0));
    check_val("ifc_fifo_head", 32'({rx_valid, rx_eoi, rx_data}), 32'(10'h233));
    dav_n = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Asynchronous reset in the middle of a data transfer.
    set_atn(1'b0);
    send_byte(1'b1, 8'h28, 1'b0);
    set_atn(1'b1);
    send_byte(1'b0, 8'h11, 1'b0);
    dio_n = ~8'h22;
    dav_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    m_q.delete();
    m_listen = 1'b0;
    m_sec = 5'd0;
    check_val("arst_lines", 32'({nrfd_n, ndac_n}), 32'(2'b11));
    check_val("arst_listen", 32'(listen), 32'(0));
    check_val("arst_fifo", 32'({rx_valid, rx_eoi, rx_data}), 32'(0));
    dav_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    set_atn(1'b0);
    send_byte(1'b1, 8'h28, 1'b0);
    check_val("post_rst_listen", 32'(listen), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ieee488_acceptor.md
IEEE488_ACCEPTOR -- requirements
Module: ieee488_acceptor

Interface
REQ-001 SHALL have parameter DEVADDR, default 5'd8: primary IEEE-488 address of this device.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries, power of two.
REQ-003 SHALL have port clk_sys, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port dav_n, input, 1: bus DAV, low = data valid.
REQ-006 SHALL have port atn_n, input, 1: bus ATN, low = command byte.
REQ-007 SHALL have port ifc_n, input, 1: bus IFC, low = interface clear.
REQ-008 SHALL have port eoi_n, input, 1: bus EOI, low = last byte.
REQ-009 SHALL have port dio_n, input, 8: bus data lines, active low.
REQ-010 SHALL have port nrfd_n, output, 1: driven NRFD, low = not ready for data.
REQ-011 SHALL have port ndac_n, output, 1: driven NDAC, low = data not accepted.
REQ-012 SHALL have port rx_data, output, 8: head-of-FIFO byte, true polarity.
REQ-013 SHALL have port rx_eoi, output, 1: EOI flag stored with rx_data.
REQ-014 SHALL have port rx_valid, output, 1: FIFO not empty.
REQ-015 SHALL have port rx_ready, input, 1: consumer pops the head when rx_valid and rx_ready are both high.
REQ-016 SHALL have port listen, output, 1: device is addressed as listener.
REQ-017 SHALL have port sec_addr, output, 5: last secondary address received while listen was set.

Function
REQ-018 SHALL pass dav_n, atn_n, ifc_n, eoi_n and dio_n through a 2-flop synchronizer; all decisions below use synchronized values (2-cycle input latency).
REQ-019 SHALL participate in the handshake when ATN is low, or when ATN is high and listen=1; otherwise both nrfd_n and ndac_n SHALL be 1 (released).
REQ-020 SHALL implement acceptor FSM IDLE, RDY, ACC, WNV:
- IDLE: nrfd_n=1, ndac_n=1.
- RDY: nrfd_n=1, ndac_n=0.
- ACC: nrfd_n=0, ndac_n=0.
- WNV: nrfd_n=0, ndac_n=1.
REQ-021 SHALL go IDLE->RDY when participation begins and dav_n=1; if dav_n=0 at entry, SHALL hold nrfd_n=0, ndac_n=0 until dav_n=1, then enter RDY.
REQ-022 SHALL go RDY->ACC on the first cycle with dav_n=0, latching ~dio_n, ~eoi_n and ~atn_n in that cycle.
REQ-023 SHALL go ACC->WNV in the following cycle, having processed the latched byte (command or FIFO write).
REQ-024 SHALL go WNV->RDY (or IDLE if no longer participating) on the first cycle with dav_n=1.
REQ-025 In RDY with the byte to be a data byte (ATN high) and the FIFO full, SHALL hold nrfd_n=0 (not ready) until an entry is popped; command bytes are never blocked.
REQ-026 SHALL decode a command byte c=~dio_n[6:0] (bit 7 ignored):
- c == 0x20|DEVADDR: set listen.
- c == 0x3F (UNL): clear listen.
- c in 0x40..0x5E with c[4:0]==DEVADDR (own TALK): clear listen.
- c in 0x60..0x7F while listen=1: sec_addr <= c[4:0].
- All other commands: no effect.
REQ-027 SHALL write a data byte (ATN high, listen=1) plus its EOI flag into the FIFO in the ACC cycle.
REQ-028 SHALL support simultaneous push and pop in one cycle, including when full (pop makes room; push accepted).
REQ-029 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and keep an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-030 On ATN falling while participating only as listener in RDY/WNV, SHALL continue in the same state; on ATN falling while in IDLE, SHALL enter RDY per REQ-021 within 1 cycle after synchronization.
REQ-031 On ifc_n=0 (synchronized), SHALL clear listen and sec_addr and force FSM to IDLE; FIFO contents SHALL be kept.

Reset
REQ-032 On reset_n=0, SHALL set FSM IDLE, nrfd_n=1, ndac_n=1, listen=0, sec_addr=0, FIFO empty (rx_valid=0, rx_data=0, rx_eoi=0), synchronizers to idle-bus value 1.

Verification
REQ-033 Bench SHALL drive ATN low, byte ~0x28 with DAV handshake (DEVADDR=8) -> listen=1, ndac_n rises after DAV low, nrfd_n returns high after DAV high.
REQ-034 Bench SHALL send 0x28, 0x62 under ATN, then data 0x41, 0x42 with EOI on the second -> sec_addr=2; FIFO pops 0x41/eoi=0, 0x42/eoi=1.
REQ-035 Bench SHALL send 5 data bytes with rx_ready=0 -> 4 accepted; nrfd_n stays 0 before the fifth; one pop -> fifth accepted.
REQ-036 Bench SHALL send 0x3F under ATN while listening, then a data byte -> listen=0; nrfd_n and ndac_n stay 1; FIFO unchanged.
REQ-037 Bench SHALL pulse ifc_n low mid-handshake (state ACC) -> listen=0, nrfd_n=ndac_n=1 within 3 cycles; prior FIFO data retained.
REQ-038 Bench SHALL assert reset_n low mid-transfer -> all outputs at reset values asynchronously, FIFO empty.
